// File: rtl/serial_async_tx_packetiser.sv
// Packet framer ahead of serial_async_tx: buffers payload words, then sends HEADER, length, payload
// (and a checksum word when SERIAL_TX_PACKET_CHECKSUM_EN is defined) over the enable/next_word handshake.
module serial_async_tx_packetiser #(
    parameter int unsigned     BITS   = 8,
    parameter int unsigned     DEPTH  = 16,
    parameter logic [BITS-1:0] HEADER = 8'hA5
) (
    input  logic                     serial_clk,
    input  logic                     in_rst,
    input  logic                     in_wr_en,
    input  logic [BITS-1:0]          in_wr_data,
    input  logic                     in_send,
    output logic                     out_full,
    output logic                     out_empty,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     out_busy,
    output logic                     out_sent,
    output logic                     out_tx_enable,
    output logic [BITS-1:0]          out_tx_data,
    input  logic                     in_tx_next_word,
    input  logic                     in_tx_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HEADER   = 3'd1,
        S_LENGTH   = 3'd2,
        S_PAYLOAD  = 3'd3,
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
        S_CHECKSUM = 3'd4,
`endif
        S_DRAIN    = 3'd5
    } state_t;

    state_t            r_state;
    logic [BITS-1:0]   r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic [BITS-1:0]   r_len;
    logic [CW-1:0]     r_left;
    logic              r_busy;
    logic              r_sent;
    logic              r_tx_enable;
    logic [BITS-1:0]   r_tx_data;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
    logic [BITS-1:0]   r_sum;
`endif

    logic              w_wr;
    logic              w_pop;
    logic [BITS-1:0]   w_head;
    logic [CW-1:0]     w_count_nxt;

    assign w_wr   = in_wr_en && !r_full;
    assign w_head = r_mem[r_rd_ptr];
    // A pop happens exactly when a payload word is loaded for the transmitter
    assign w_pop  = in_tx_next_word && (r_left != '0) &&
                    ((r_state == S_LENGTH) || (r_state == S_PAYLOAD));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge serial_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_wr_data;
        end
    end

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Packet sequencer; each word is held until the transmitter asks for the next one
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_left      <= '0;
            r_busy      <= 1'b0;
            r_sent      <= 1'b0;
            r_tx_enable <= 1'b0;
            r_tx_data   <= '0;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_sent <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_send) begin
                        r_tx_data   <= HEADER;
                        r_tx_enable <= 1'b1;
                        r_busy      <= 1'b1;
                        r_len       <= BITS'(r_count);
                        r_left      <= r_count;
                        r_state     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (in_tx_next_word) begin
                        r_tx_data <= r_len;
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
                        r_sum     <= r_len;
`endif
                        r_state   <= S_LENGTH;
                    end
                end
                S_LENGTH, S_PAYLOAD: begin
                    if (in_tx_next_word) begin
                        if (r_left != '0) begin
                            r_tx_data <= w_head;
                            r_left    <= r_left - CW'(1);
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
                            r_sum     <= r_sum + w_head;
`endif
                            r_state   <= S_PAYLOAD;
                        end else begin
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
                            r_tx_data   <= r_sum;
                            r_state     <= S_CHECKSUM;
`else
                            r_tx_enable <= 1'b0;
                            r_state     <= S_DRAIN;
`endif
                        end
                    end
                end
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (in_tx_next_word) begin
                        r_tx_enable <= 1'b0;
                        r_state     <= S_DRAIN;
                    end
                end
`endif
                S_DRAIN: begin
                    if (in_tx_ready) begin
                        r_sent  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_full      = r_full;
    assign out_empty     = r_empty;
    assign out_count     = r_count;
    assign out_busy      = r_busy;
    assign out_sent      = r_sent;
    assign out_tx_enable = r_tx_enable;
    assign out_tx_data   = r_tx_data;

endmodule

// File: tb/tb_serial_async_tx_packetiser.sv
// Bench for serial_async_tx_packetiser: a behavioural transmitter records each word it is handed, and
// a queue-based packet model predicts the line words; honours SERIAL_TX_PACKET_CHECKSUM_EN either way.
module tb_serial_async_tx_packetiser;

    localparam int unsigned BITS  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [7:0]  HDR   = 8'hA5;

    logic          serial_clk;
    logic          in_rst;
    logic          in_wr_en;
    logic [7:0]    in_wr_data;
    logic          in_send;
    logic          out_full;
    logic          out_empty;
    logic [CW-1:0] out_count;
    logic          out_busy;
    logic          out_sent;
    logic          out_tx_enable;
    logic [7:0]    out_tx_data;
    logic          in_tx_next_word;
    logic          in_tx_ready;

    int n_vec;
    int n_err;
    int sent_cnt;
    logic [7:0] model_q[$];
    logic [7:0] line_q[$];

    serial_async_tx_packetiser #(.BITS(BITS), .DEPTH(DEPTH), .HEADER(HDR)) dut (
        .serial_clk      (serial_clk),
        .in_rst          (in_rst),
        .in_wr_en        (in_wr_en),
        .in_wr_data      (in_wr_data),
        .in_send         (in_send),
        .out_full        (out_full),
        .out_empty       (out_empty),
        .out_count       (out_count),
        .out_busy        (out_busy),
        .out_sent        (out_sent),
        .out_tx_enable   (out_tx_enable),
        .out_tx_data     (out_tx_data),
        .in_tx_next_word (in_tx_next_word),
        .in_tx_ready     (in_tx_ready)
    );

    initial begin
        serial_clk = 1'b0;
        forever #5 serial_clk = ~serial_clk;
    end

    // Transmitter stand-in: random word durations, next_word in the last data bit, 1-3 stop cycles
    initial begin
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        in_tx_next_word = 1'b0;
        in_tx_ready = 1'b1;
        forever begin
            @(negedge serial_clk);
            in_tx_next_word = 1'b0;
            if (in_rst === 1'b1) begin
                st = 0;
                in_tx_ready = 1'b1;
            end else begin
                case (st)
                    0: if (out_tx_enable === 1'b1) begin
                        in_tx_ready = 1'b0;
                        cnt = $urandom_range(2, 11);
                        st = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            in_tx_next_word = 1'b1;
                            line_q.push_back(out_tx_data);
                            st = 2;
                        end
                    end
                    2: if (out_tx_enable === 1'b1) begin
                        cnt = $urandom_range(2, 11);
                        st = 1;
                    end else begin
                        cnt = $urandom_range(1, 3);
                        st = 3;
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            in_tx_ready = 1'b1;
                            st = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        sent_cnt = 0;
        forever begin
            @(negedge serial_clk);
            if (out_sent === 1'b1) sent_cnt++;
        end
    end

    task automatic write_word(input logic [7:0] d);
        @(negedge serial_clk);
        in_wr_en = 1'b1;
        in_wr_data = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        @(posedge serial_clk);
        #1;
        in_wr_en = 1'b0;
    endtask

    // Sends whatever the model FIFO holds and checks the words seen by the transmitter
    task automatic run_packet(input int n_extra, input logic [7:0] extra_first, input bit hold);
        logic [7:0] exp_q[$];
        logic [7:0] sum;
        int len;
        int base_sent;
        int extra_left;
        bit seen;
        len = model_q.size();
        exp_q = {};
        exp_q.push_back(HDR);
        exp_q.push_back(8'(len));
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(model_q[i]);
            sum = sum + model_q[i];
        end
`ifdef SERIAL_TX_PACKET_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        line_q.delete();
        base_sent = sent_cnt;
        @(negedge serial_clk);
        in_send = 1'b1;
        @(posedge serial_clk);
        #1;
        n_vec++;
        if ({out_busy, out_tx_enable, out_tx_data} !== {1'b1, 1'b1, HDR}) begin
            n_err++;
            $display("FAIL send_latency: busy/en/data got %b/%b/%h want 1/1/%h",
                     out_busy, out_tx_enable, out_tx_data, HDR);
        end
        seen = 1'b0;
        extra_left = n_extra;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge serial_clk);
            in_wr_en = 1'b0;
            if (!hold) in_send = 1'b0;
            if (out_sent === 1'b1) begin
                seen = 1'b1;
                in_send = 1'b0;
                n_vec++;
                if (out_count !== CW'(model_q.size() - len)) begin
                    n_err++;
                    $display("FAIL count_at_sent: got %0d want %0d", out_count, model_q.size() - len);
                end
            end else if (extra_left > 0 && (i % 4) == 2 && model_q.size() < DEPTH) begin
                in_wr_en = 1'b1;
                in_wr_data = (extra_left == n_extra) ? extra_first : 8'($urandom);
                model_q.push_back(in_wr_data);
                extra_left--;
            end
        end
        in_wr_en = 1'b0;
        in_send = 1'b0;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL sent_timeout: out_sent got 0 want 1 within 3000 cycles");
        end
        repeat (4) @(negedge serial_clk);
        n_vec++;
        if (sent_cnt - base_sent !== 1) begin
            n_err++;
            $display("FAIL sent_pulses: got %0d want 1", sent_cnt - base_sent);
        end
        n_vec++;
        if ({out_busy, out_tx_enable, out_sent} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after: busy/en/sent got %b want 000", {out_busy, out_tx_enable, out_sent});
        end
        n_vec++;
        if (line_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL line_len: got %0d words want %0d", line_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < line_q.size(); i++) begin
            n_vec++;
            if (line_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL line_word[%0d]: got %h want %h", i, line_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < len; i++) void'(model_q.pop_front());
        n_vec++;
        if ({out_count, out_empty, out_full} !== {CW'(model_q.size()), model_q.size() == 0,
                                                  model_q.size() == DEPTH}) begin
            n_err++;
            $display("FAIL fifo_after: count/empty/full got %0d/%b/%b want %0d/%b/%b", out_count,
                     out_empty, out_full, model_q.size(), model_q.size() == 0, model_q.size() == DEPTH);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if ({out_tx_enable, out_tx_data, out_busy, out_sent, out_full, out_empty, out_count} !==
            {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}) begin
            n_err++;
            $display("FAIL %s: en=%b data=%h busy=%b sent=%b full=%b empty=%b count=%0d want 0/00/0/0/0/1/0",
                     tag, out_tx_enable, out_tx_data, out_busy, out_sent, out_full, out_empty, out_count);
        end
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        repeat (3) @(negedge serial_clk);
        check_reset_values("reset_values");
        in_rst = 1'b0;
        repeat (2) @(negedge serial_clk);
    endtask

    task automatic test_reset_mid_packet();
        bit reached;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        line_q.delete();
        @(negedge serial_clk);
        in_send = 1'b1;
        @(negedge serial_clk);
        in_send = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge serial_clk);
            if (line_q.size() >= 3) reached = 1'b1;
        end
        n_vec++;
        if (!reached) begin
            n_err++;
            $display("FAIL reach_payload: got %0d words want 3 within 500 cycles", line_q.size());
        end
        in_rst = 1'b1;
        @(posedge serial_clk);
        #1;
        check_reset_values("reset_mid_packet");
        @(negedge serial_clk);
        in_rst = 1'b0;
        model_q.delete();
        line_q.delete();
        repeat (3) @(negedge serial_clk);
        check_reset_values("after_reset_release");
    endtask

    task automatic test_basic();
        write_word(8'h01);
        write_word(8'h02);
        write_word(8'h03);
        run_packet(0, 8'h00, 1'b0);
    endtask

    task automatic test_empty();
        run_packet(0, 8'h00, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            write_word(8'hFF);
            if (i == 15 || i == 16) begin
                n_vec++;
                if ({out_full, out_count} !== {1'b1, CW'(DEPTH)}) begin
                    n_err++;
                    $display("FAIL fill_%0d: full/count got %b/%0d want 1/%0d", i + 1, out_full,
                             out_count, DEPTH);
                end
            end else if (i == 14) begin
                n_vec++;
                if ({out_full, out_count} !== {1'b0, CW'(15)}) begin
                    n_err++;
                    $display("FAIL fill_15: full/count got %b/%0d want 0/15", out_full, out_count);
                end
            end
        end
        run_packet(0, 8'h00, 1'b0);
    endtask

    task automatic test_write_during_packet();
        write_word(8'($urandom));
        write_word(8'($urandom));
        run_packet(1, 8'h55, 1'b0);
        n_vec++;
        if (model_q.size() != 1 || out_count !== CW'(1)) begin
            n_err++;
            $display("FAIL leftover: count got %0d want 1", out_count);
        end
        run_packet(0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n;
            n = $urandom_range(0, 9);
            for (int k = 0; k < n; k++) write_word(8'($urandom));
            run_packet($urandom_range(0, 3), 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        in_rst = 1'b1;
        in_wr_en = 1'b0;
        in_wr_data = 8'h00;
        in_send = 1'b0;
        test_reset();
        test_reset_mid_packet();
        test_basic();
        test_empty();
        test_fill();
        test_write_during_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
